rx_phy_align: RTL and testbench

//  Receive dword aligner between the GTX receiver and the primitive/CRC stage (phy2cs_* consumer).

---
 rtl/rx_phy_align_pkg.sv | 13 +
 rtl/rx_byte_rotate.sv | 37 +++
 rtl/rx_phy_align.sv | 223 ++++++++++++++++++++++
 tb/tb_rx_phy_align.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_phy_align_pkg.sv
// Shared constants and state encoding for the receive dword aligner.
package rx_phy_align_pkg;

  localparam logic [31:0] P_ALIGN = 32'h7B4A_4ABC;
  localparam logic [7:0]  K28_5   = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    SYNC   = 2'd2
  } align_state_t;

endpackage

// File: rtl/rx_byte_rotate.sv
// Combinational byte rotator: selects the 4-byte window of {cur,prev} that starts
// at the lane of prev where the locked K28.5 sits, with K/err bits steered identically.
module rx_byte_rotate (
  input  logic [63:0] data_in,
  input  logic [7:0]  k_in,
  input  logic [7:0]  err_in,
  input  logic [1:0]  offset,
  output logic [31:0] data_out,
  output logic [3:0]  k_out,
  output logic [3:0]  err_out
);

  always_comb begin
    data_out = data_in[31:0];
    k_out    = k_in[3:0];
    err_out  = err_in[3:0];
    case (offset)
      2'd1: begin
        data_out = data_in[39:8];
        k_out    = k_in[4:1];
        err_out  = err_in[4:1];
      end
      2'd2: begin
        data_out = data_in[47:16];
        k_out    = k_in[5:2];
        err_out  = err_in[5:2];
      end
      2'd3: begin
        data_out = data_in[55:24];
        k_out    = k_in[6:3];
        err_out  = err_in[6:3];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_phy_align.sv
// Receive dword aligner with HUNT/VERIFY/SYNC qualification and code-error windowing.
// Optional statistics on align2dbg are built when SATA_RX_ALIGN_STATS_EN is defined.
module rx_phy_align
  import rx_phy_align_pkg::*;
#(
  parameter int C_LOCK_CNT   = 4,
  parameter int C_ERR_LIMIT  = 4,
  parameter int C_ERR_WINDOW = 64
) (
  input  logic        clk_75m,
  input  logic        host_rst_n,
  input  logic [31:0] gtx_rxdata,
  input  logic [3:0]  gtx_rxdatak,
  input  logic [3:0]  gtx_rxdisperr,
  input  logic [3:0]  gtx_rxnotintable,
  output logic [31:0] phy2cs_data,
  output logic        phy2cs_k,
  output logic        rx_sync,
  output logic [1:0]  rx_lane,
  output logic        rx_code_err,
  output logic [31:0] align2dbg
);

  localparam int                WIN_W      = $clog2(C_ERR_WINDOW);
  localparam logic [2:0]        LOCK_CNT3  = 3'(C_LOCK_CNT);
  localparam logic [3:0]        ERR_LIMIT4 = 4'(C_ERR_LIMIT);
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(C_ERR_WINDOW - 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic inc);
    return (inc && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  function automatic logic [1:0] first_lane(input logic [3:0] h);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--) if (h[i]) l = 2'(i);
    return l;
  endfunction

  logic [3:0]  hit_vec;
  logic        hit;
  logic [1:0]  hit_lane;
  logic [3:0]  raw_err;

  always_comb begin
    for (int i = 0; i < 4; i++)
      hit_vec[i] = gtx_rxdatak[i] && (gtx_rxdata[8*i +: 8] == K28_5);
    hit      = |hit_vec;
    hit_lane = first_lane(hit_vec);
    raw_err  = gtx_rxdisperr | gtx_rxnotintable;
  end

  // Stage 1: previous raw word and flags
  logic [31:0] prev_data_p1_q, prev_data_p1_d;
  logic [3:0]  prev_k_p1_q, prev_k_p1_d;
  logic [3:0]  prev_err_p1_q, prev_err_p1_d;

  always_comb begin
    prev_data_p1_d = gtx_rxdata;
    prev_k_p1_d    = gtx_rxdatak;
    prev_err_p1_d  = raw_err;
  end

  logic [31:0] rot_data;
  logic [3:0]  rot_k;
  logic [3:0]  rot_err;
  logic [1:0]  rx_lane_q, rx_lane_d;

  rx_byte_rotate u_rotate (
    .data_in  ({gtx_rxdata, prev_data_p1_q}),
    .k_in     ({gtx_rxdatak, prev_k_p1_q}),
    .err_in   ({raw_err, prev_err_p1_q}),
    .offset   (rx_lane_q),
    .data_out (rot_data),
    .k_out    (rot_k),
    .err_out  (rot_err)
  );

  logic aligned_err;
  assign aligned_err = (|rot_err) || (|rot_k[3:1]);

  align_state_t     state_q, state_d;
  logic [1:0]       lane_cand_q, lane_cand_d;
  logic [2:0]       hit_cnt_q, hit_cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_wrap;

  always_comb begin
    state_d     = state_q;
    lane_cand_d = lane_cand_q;
    hit_cnt_d   = hit_cnt_q;
    rx_lane_d   = rx_lane_q;
    err_cnt_d   = err_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_wrap    = 1'b0;
    case (state_q)
      HUNT: begin
        if (hit) begin
          lane_cand_d = hit_lane;
          hit_cnt_d   = 3'd1;
          if (LOCK_CNT3 <= 3'd1) begin
            state_d   = SYNC;
            rx_lane_d = hit_lane;
          end else begin
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (|raw_err || (hit && hit_lane != lane_cand_q)) begin
          state_d   = HUNT;
          hit_cnt_d = 3'd0;
        end else if (hit) begin
          hit_cnt_d = hit_cnt_q + 3'd1;
          if (hit_cnt_d >= LOCK_CNT3) begin
            state_d   = SYNC;
            rx_lane_d = lane_cand_q;
          end
        end
      end
      SYNC: begin
        // An error on the wrap dword opens the new window with a count of one
        win_wrap  = (win_cnt_q == WIN_LAST);
        win_cnt_d = win_cnt_q + WIN_W'(1);
        err_cnt_d = win_wrap ? {3'b000, aligned_err} : sat_inc4(err_cnt_q, aligned_err);
        if ((hit && hit_lane != rx_lane_q) || err_cnt_d >= ERR_LIMIT4) begin
          state_d   = HUNT;
          hit_cnt_d = 3'd0;
          win_cnt_d = '0;
          err_cnt_d = 4'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Stage 2: output register, data forced to filler outside SYNC
  logic [31:0] out_data_p2_q, out_data_p2_d;
  logic        out_k_p2_q, out_k_p2_d;
  logic        vld_p2_q, vld_p2_d;
  logic        code_err_p2_q, code_err_p2_d;

  always_comb begin
    out_data_p2_d = P_ALIGN;
    out_k_p2_d    = 1'b1;
    vld_p2_d      = 1'b0;
    code_err_p2_d = 1'b0;
    if (state_q == SYNC) begin
      out_data_p2_d = rot_data;
      out_k_p2_d    = rot_k[0];
      vld_p2_d      = 1'b1;
      code_err_p2_d = aligned_err;
    end
  end

  always_ff @(posedge clk_75m or negedge host_rst_n) begin
    if (!host_rst_n) begin
      prev_data_p1_q <= '0;
      prev_k_p1_q    <= '0;
      prev_err_p1_q  <= '0;
      state_q        <= HUNT;
      lane_cand_q    <= '0;
      hit_cnt_q      <= '0;
      rx_lane_q      <= '0;
      err_cnt_q      <= '0;
      win_cnt_q      <= '0;
      out_data_p2_q  <= P_ALIGN;
      out_k_p2_q     <= 1'b1;
      vld_p2_q       <= 1'b0;
      code_err_p2_q  <= 1'b0;
    end else begin
      prev_data_p1_q <= prev_data_p1_d;
      prev_k_p1_q    <= prev_k_p1_d;
      prev_err_p1_q  <= prev_err_p1_d;
      state_q        <= state_d;
      lane_cand_q    <= lane_cand_d;
      hit_cnt_q      <= hit_cnt_d;
      rx_lane_q      <= rx_lane_d;
      err_cnt_q      <= err_cnt_d;
      win_cnt_q      <= win_cnt_d;
      out_data_p2_q  <= out_data_p2_d;
      out_k_p2_q     <= out_k_p2_d;
      vld_p2_q       <= vld_p2_d;
      code_err_p2_q  <= code_err_p2_d;
    end
  end

  assign phy2cs_data = out_data_p2_q;
  assign phy2cs_k    = out_k_p2_q;
  assign rx_sync     = vld_p2_q;
  assign rx_lane     = rx_lane_q;
  assign rx_code_err = code_err_p2_q;

`ifdef SATA_RX_ALIGN_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] cerr_cnt_q, cerr_cnt_d;

  always_comb begin
    drop_cnt_d = sat_inc16(drop_cnt_q, (state_q == SYNC) && (state_d != SYNC));
    cerr_cnt_d = sat_inc16(cerr_cnt_q, code_err_p2_d);
  end

  always_ff @(posedge clk_75m or negedge host_rst_n) begin
    if (!host_rst_n) begin
      drop_cnt_q <= '0;
      cerr_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      cerr_cnt_q <= cerr_cnt_d;
    end
  end

  assign align2dbg = {cerr_cnt_q, drop_cnt_q};
`else
  assign align2dbg = 32'h0;
`endif

endmodule

// File: tb/tb_rx_phy_align.sv
// Directed bench for rx_phy_align: lock in lane 0 and lane 2, misalignment drop,
// code-error windowing and asynchronous reset.
module tb_rx_phy_align;

  localparam logic [31:0] ALIGN_W = 32'h7B4A_4ABC;
  // Lane-2 split primitive: A carries BC/4A in lanes 2/3, B carries 4A/7B in lanes 0/1.
  localparam logic [31:0] SPLIT_A = 32'h4ABC_0000;
  localparam logic [31:0] SPLIT_B = 32'hF00D_7B4A;
  localparam logic [31:0] SPLIT_Z = 32'h0000_CAFE;

  logic        clk_75m = 1'b0;
  logic        host_rst_n = 1'b0;
  logic [31:0] gtx_rxdata = '0;
  logic [3:0]  gtx_rxdatak = '0;
  logic [3:0]  gtx_rxdisperr = '0;
  logic [3:0]  gtx_rxnotintable = '0;
  logic [31:0] phy2cs_data;
  logic        phy2cs_k;
  logic        rx_sync;
  logic [1:0]  rx_lane;
  logic        rx_code_err;
  logic [31:0] align2dbg;

  int n_checks = 0;
  int n_fail = 0;

  rx_phy_align dut (
    .clk_75m          (clk_75m),
    .host_rst_n       (host_rst_n),
    .gtx_rxdata       (gtx_rxdata),
    .gtx_rxdatak      (gtx_rxdatak),
    .gtx_rxdisperr    (gtx_rxdisperr),
    .gtx_rxnotintable (gtx_rxnotintable),
    .phy2cs_data      (phy2cs_data),
    .phy2cs_k         (phy2cs_k),
    .rx_sync          (rx_sync),
    .rx_lane          (rx_lane),
    .rx_code_err      (rx_code_err),
    .align2dbg        (align2dbg)
  );

  always #5 clk_75m = ~clk_75m;

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de);
    @(posedge clk_75m); #1;
    gtx_rxdata = d; gtx_rxdatak = k; gtx_rxdisperr = de; gtx_rxnotintable = 4'h0;
  endtask

  task automatic cyc_nit(input logic [31:0] d, input logic [3:0] ni);
    @(posedge clk_75m); #1;
    gtx_rxdata = d; gtx_rxdatak = 4'h0; gtx_rxdisperr = 4'h0; gtx_rxnotintable = ni;
  endtask

  task automatic lock_lane0();
    repeat (3) begin
      cyc(ALIGN_W, 4'b0001, 4'h0);
      repeat (7) cyc(32'h0, 4'h0, 4'h0);
    end
    cyc(ALIGN_W, 4'b0001, 4'h0);
  endtask

  task automatic lock_lane2();
    repeat (3) begin
      cyc(SPLIT_A, 4'b0100, 4'h0);
      cyc(SPLIT_B, 4'h0, 4'h0);
      repeat (6) cyc(32'h0, 4'h0, 4'h0);
    end
    cyc(SPLIT_A, 4'b0100, 4'h0);
  endtask

  task automatic test_reset();
    host_rst_n = 1'b0;
    repeat (3) @(posedge clk_75m);
    #1;
    n_checks++; if (phy2cs_data !== ALIGN_W) begin n_fail++; $display("FAIL reset_data: got %h want %h", phy2cs_data, ALIGN_W); end
    n_checks++; if (phy2cs_k !== 1'b1) begin n_fail++; $display("FAIL reset_k: got %b want 1", phy2cs_k); end
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", rx_sync); end
    n_checks++; if (rx_code_err !== 1'b0) begin n_fail++; $display("FAIL reset_code_err: got %b want 0", rx_code_err); end
    n_checks++; if (align2dbg !== 32'h0) begin n_fail++; $display("FAIL reset_dbg: got %h want 0", align2dbg); end
    host_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(32'h0, 4'h0, 4'h0);
      n_checks++;
      if (rx_sync !== 1'b0 || phy2cs_data !== ALIGN_W || phy2cs_k !== 1'b1) begin
        n_fail++; $display("FAIL idle_filler[%0d]: got sync=%b data=%h k=%b want 0 %h 1", i, rx_sync, phy2cs_data, phy2cs_k, ALIGN_W);
      end
    end
  endtask

  task automatic test_lock_lane0();
    repeat (3) begin
      cyc(ALIGN_W, 4'b0001, 4'h0);
      repeat (7) cyc(32'h0, 4'h0, 4'h0);
    end
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL lane0_3hits_sync: got %b want 0", rx_sync); end
    cyc(ALIGN_W, 4'b0001, 4'h0);
    cyc(32'h1234_5678, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL lane0_pre_sync: got %b want 0", rx_sync); end
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL lane0_sync: got %b want 1", rx_sync); end
    n_checks++; if (phy2cs_data !== ALIGN_W || phy2cs_k !== 1'b1) begin n_fail++; $display("FAIL lane0_prim: got %h k=%b want %h k=1", phy2cs_data, phy2cs_k, ALIGN_W); end
    n_checks++; if (rx_lane !== 2'd0) begin n_fail++; $display("FAIL lane0_lane: got %0d want 0", rx_lane); end
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (phy2cs_data !== 32'h1234_5678 || phy2cs_k !== 1'b0) begin n_fail++; $display("FAIL lane0_dword: got %h k=%b want 12345678 k=0", phy2cs_data, phy2cs_k); end
  endtask

  task automatic test_lock_lane2();
    host_rst_n = 1'b0;
    repeat (2) @(posedge clk_75m);
    #1 host_rst_n = 1'b1;
    lock_lane2();
    cyc(SPLIT_B, 4'h0, 4'h0);
    cyc(SPLIT_Z, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b1 || rx_lane !== 2'd2) begin n_fail++; $display("FAIL lane2_lock: got sync=%b lane=%0d want 1 2", rx_sync, rx_lane); end
    n_checks++; if (phy2cs_data !== ALIGN_W || phy2cs_k !== 1'b1) begin n_fail++; $display("FAIL lane2_prim: got %h k=%b want %h k=1", phy2cs_data, phy2cs_k, ALIGN_W); end
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (phy2cs_data !== 32'hCAFE_F00D || phy2cs_k !== 1'b0) begin n_fail++; $display("FAIL lane2_dword: got %h k=%b want cafef00d k=0", phy2cs_data, phy2cs_k); end
  endtask

  task automatic test_misalign();
    cyc(32'h0, 4'h0, 4'h0);
    cyc(32'h0, 4'h0, 4'h0);
    cyc(32'h0000_BC00, 4'b0010, 4'h0);
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL misalign_before: got %b want 1", rx_sync); end
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b0 || phy2cs_data !== ALIGN_W || phy2cs_k !== 1'b1) begin
      n_fail++; $display("FAIL misalign_drop: got sync=%b data=%h k=%b want 0 %h 1", rx_sync, phy2cs_data, phy2cs_k, ALIGN_W);
    end
    repeat (3) begin
      cyc(ALIGN_W, 4'b0001, 4'h0);
      repeat (7) cyc(32'h0, 4'h0, 4'h0);
    end
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", rx_sync); end
    cyc(ALIGN_W, 4'b0001, 4'h0);
    cyc(32'h0, 4'h0, 4'h0);
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b1 || rx_lane !== 2'd0 || phy2cs_data !== ALIGN_W) begin
      n_fail++; $display("FAIL relock: got sync=%b lane=%0d data=%h want 1 0 %h", rx_sync, rx_lane, phy2cs_data, ALIGN_W);
    end
  endtask

  task automatic test_code_err();
    int pulses;
    pulses = 0;
    repeat (4) begin
      cyc(32'h0, 4'h0, 4'b0001);
      pulses += int'(rx_code_err);
    end
    repeat (8) begin
      cyc(32'h0, 4'h0, 4'h0);
      pulses += int'(rx_code_err);
    end
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL err_limit_pulses: got %0d want 4", pulses); end
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL err_limit_hunt: got sync=%b want 0", rx_sync); end
  endtask

  task automatic test_err_window();
    int pulses;
    pulses = 0;
    lock_lane0();
    for (int i = 1; i <= 80; i++) begin
      if (i == 1 || i == 2 || i == 3 || i == 63 || i == 71) cyc(32'h0, 4'h0, 4'b0001);
      else if (i == 70) cyc_nit(32'h0, 4'b0001);
      else cyc(32'h0, 4'h0, 4'h0);
      pulses += int'(rx_code_err);
    end
    n_checks++; if (pulses != 6) begin n_fail++; $display("FAIL window_pulses: got %0d want 6", pulses); end
    n_checks++; if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL window_stay_sync: got %b want 1", rx_sync); end
    cyc(32'h0, 4'h0, 4'b0001);
    pulses += int'(rx_code_err);
    repeat (3) begin
      cyc(32'h0, 4'h0, 4'h0);
      pulses += int'(rx_code_err);
    end
    n_checks++; if (pulses != 7) begin n_fail++; $display("FAIL window2_pulses: got %0d want 7", pulses); end
    n_checks++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL window2_hunt: got %b want 0", rx_sync); end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_dbg;
`ifdef SATA_RX_ALIGN_STATS_EN
    exp_dbg = {16'd12, 16'd3};
`else
    exp_dbg = 32'h0;
`endif
    lock_lane2();
    cyc(SPLIT_B, 4'h0, 4'h0);
    cyc(SPLIT_Z, 4'h0, 4'h0);
    cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b1 || rx_lane !== 2'd2 || phy2cs_data !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL pre_reset: got sync=%b lane=%0d data=%h want 1 2 cafef00d", rx_sync, rx_lane, phy2cs_data);
    end
    n_checks++; if (align2dbg !== exp_dbg) begin n_fail++; $display("FAIL stats: got %h want %h", align2dbg, exp_dbg); end
    #2 host_rst_n = 1'b0;
    #1;
    n_checks++; if (phy2cs_data !== ALIGN_W || phy2cs_k !== 1'b1) begin n_fail++; $display("FAIL async_data: got %h k=%b want %h k=1", phy2cs_data, phy2cs_k, ALIGN_W); end
    n_checks++; if (rx_sync !== 1'b0 || rx_lane !== 2'd0 || rx_code_err !== 1'b0) begin
      n_fail++; $display("FAIL async_ctrl: got sync=%b lane=%0d err=%b want 0 0 0", rx_sync, rx_lane, rx_code_err);
    end
    n_checks++; if (align2dbg !== 32'h0) begin n_fail++; $display("FAIL async_dbg: got %h want 0", align2dbg); end
    repeat (2) @(posedge clk_75m);
    #1 host_rst_n = 1'b1;
    repeat (5) cyc(32'h0, 4'h0, 4'h0);
    n_checks++; if (rx_sync !== 1'b0 || phy2cs_data !== ALIGN_W) begin n_fail++; $display("FAIL post_reset: got sync=%b data=%h want 0 %h", rx_sync, phy2cs_data, ALIGN_W); end
  endtask

  initial begin
    test_reset();
    test_lock_lane0();
    test_lock_lane2();
    test_misalign();
    test_code_err();
    test_err_window();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
